// File: rtl/instr_encoder.sv
// Encodes ALU micro-op requests into RV32I R/I-type words and queues them in a
// DEPTH-entry FIFO drained through a valid/ready handshake.
module instr_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_alu_op,
    input  logic                       in_use_imm,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [11:0]                in_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       err_illegal,
    output logic [CNT_W-1:0]           issued_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [31:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           r_alive;
    logic           r_err;
    logic [CNT_W-1:0] r_issued;

    logic [2:0]     w_func3;
    logic [6:0]     w_func7;
    logic [11:0]    w_imm;
    logic [31:0]    w_word;
    logic           w_illegal;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;

    always_comb begin
        w_func3 = 3'b000;
        w_func7 = 7'b0000000;
        w_imm   = in_imm;
        unique case (in_alu_op)
            3'b000: w_func3 = 3'b000;
            3'b001: begin
                w_func3 = 3'b000;
                w_func7 = 7'b0100000;
            end
            3'b010: w_func3 = 3'b010;
            3'b011: w_func3 = 3'b001;
            3'b100: w_func3 = 3'b101;
            3'b101: w_func3 = 3'b111;
            3'b110: w_func3 = 3'b110;
            3'b111: w_func3 = 3'b100;
            default: w_func3 = 3'b000;
        endcase
        // I-type shifts carry only the 5-bit shamt; upper imm bits are dropped
        if (in_alu_op == 3'b011 || in_alu_op == 3'b100) begin
            w_imm = {7'b0000000, in_imm[4:0]};
        end
        if (in_use_imm) begin
            w_word = {w_imm, in_rs1, w_func3, in_rd, 7'b0010011};
        end else begin
            w_word = {w_func7, in_rs2, in_rs1, w_func3, in_rd, 7'b0110011};
        end
    end

    // in_ready is held low until the first edge after reset release
    assign in_ready   = r_alive && (r_count < C_FULL);
    assign out_valid  = (r_count != '0);
    assign out_instr  = r_mem[r_rd_ptr];
    assign fill_level = r_count;
    assign err_illegal = r_err;
    assign issued_cnt  = r_issued;

    assign w_illegal = (in_alu_op == 3'b001) && in_use_imm;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && !w_illegal;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_alive  <= 1'b0;
            r_err    <= 1'b0;
            r_issued <= '0;
        end else begin
            r_alive <= 1'b1;
            r_err   <= w_accept && w_illegal;
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_issued <= r_issued + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against a queue-based
// reference model that encodes instructions arithmetically.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_alu_op;
    logic        in_use_imm;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [11:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  fill_level;
    logic        err_illegal;
    logic [15:0] issued_cnt;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_use_imm(in_use_imm),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .fill_level(fill_level), .err_illegal(err_illegal), .issued_cnt(issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_q[$];
    logic [15:0] m_issued;
    bit          m_err;
    bit          m_alive;

    function automatic logic [31:0] ref_enc(int op, bit imm_sel, int rd, int rs1, int rs2, int imm);
        int f3tab[8] = '{0, 0, 2, 1, 5, 7, 6, 4};
        int f3 = f3tab[op];
        longint w;
        if (imm_sel) begin
            int iv = (op == 3 || op == 4) ? (imm % 32) : imm;
            w = iv * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h13;
        end else begin
            int f7 = (op == 1) ? 32 : 0;
            w = f7 * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h33;
        end
        return w[31:0];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("fill_level", 32'(fill_level), 32'(m_q.size()));
        chk("issued_cnt", 32'(issued_cnt), 32'(m_issued));
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
        chk("in_ready", 32'(in_ready), 32'(m_alive && m_q.size() < DEPTH));
        if (m_q.size() > 0) chk("out_instr", out_instr, m_q[0]);
    endtask

    task automatic tick();
        bit acc, ill, pop;
        logic [31:0] w;
        @(posedge clk);
        acc = in_valid && m_alive && (m_q.size() < DEPTH);
        ill = (in_alu_op == 3'd1) && in_use_imm;
        pop = (m_q.size() > 0) && out_ready;
        w   = ref_enc(int'(in_alu_op), in_use_imm, int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_imm));
        if (pop) begin
            void'(m_q.pop_front());
            m_issued++;
        end
        if (acc && !ill) m_q.push_back(w);
        m_err = acc && ill;
        if (rst_n) m_alive = 1'b1;
        #1;
        check_all();
    endtask

    task automatic req(int op, bit ui, int rd, int rs1, int rs2, int imm);
        in_valid   = 1'b1;
        in_alu_op  = 3'(op);
        in_use_imm = ui;
        in_rd      = 5'(rd);
        in_rs1     = 5'(rs1);
        in_rs2     = 5'(rs2);
        in_imm     = 12'(imm);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_issued = '0;
        m_err    = 1'b0;
        m_alive  = 1'b0;
    endtask

    logic [15:0] base_issued;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_alu_op = '0; in_use_imm = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        model_reset();
        #2;
        check_all();
        chk("reset_out_instr", out_instr, 32'h0);
        #10 rst_n = 1'b1;
        tick();

        // 1: ADD x3,x1,x2
        out_ready = 1'b1;
        req(0, 0, 3, 1, 2, 0);
        tick();
        chk("add_word", out_instr, 32'h002081B3);
        in_valid = 1'b0;
        tick();
        chk("add_issued", 32'(issued_cnt), 32'd1);

        // 2: SUB and ADDI
        req(1, 0, 5, 6, 7, 0);
        tick();
        chk("sub_word", out_instr, 32'h407302B3);
        req(0, 1, 1, 0, 0, 'hFFF);
        tick();
        chk("addi_word", out_instr, 32'hFFF00093);
        // 3: SLLI with upper imm bits set
        req(3, 1, 2, 2, 0, 'h803);
        tick();
        chk("slli_word", out_instr, 32'h00311113);
        chk("slli_no_err", 32'(err_illegal), 32'd0);
        in_valid = 1'b0;
        tick();

        // 4: fill to full with consumer stalled
        out_ready = 1'b0;
        base_issued = m_issued;
        for (int i = 0; i < 5; i++) begin
            req(i + 2, i[0], i + 10, i + 3, i + 20, 'h100 + i);
            tick();
        end
        chk("full_level", 32'(fill_level), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("drain_issued", 32'(issued_cnt - base_issued), 32'd5);

        // 5: illegal SUBI request
        req(1, 1, 4, 4, 4, 'h123);
        tick();
        chk("illegal_pulse", 32'(err_illegal), 32'd1);
        chk("illegal_level", 32'(fill_level), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("illegal_one_cycle", 32'(err_illegal), 32'd0);

        // 6: reset with three words queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req(5, 0, i + 1, 2, 3, 0);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        req(0, 0, 3, 1, 2, 0);
        tick();
        chk("post_reset_add", out_instr, 32'h002081B3);
        in_valid = 1'b0;
        tick();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                req($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 4095));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
